// File: rtl/conv_writeback.sv
// Write-back stage behind the convolution array. It drops the padding columns,
// accumulates partial sums in an external psum RAM and emits ReLU'd pixels on the final pass.
module conv_writeback #(
  parameter int DATA_W    = 16,
  parameter int ACC_W     = 32,
  parameter int ROW_LEN   = 226,
  parameter int COL_VALID = 224,
  parameter int PIX_TOTAL = 50176
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pass_start,
  input  logic              first_pass,
  input  logic              last_pass,
  input  logic [DATA_W-1:0] bias_in,
  input  logic              in_valid,
  input  logic [ACC_W-1:0]  in_data,
  output logic              psum_rd_en,
  output logic [15:0]       psum_rd_addr,
  input  logic [ACC_W-1:0]  psum_rd_data,
  output logic              psum_wr_en,
  output logic [15:0]       psum_wr_addr,
  output logic [ACC_W-1:0]  psum_wr_data,
  output logic              fmap_wr_en,
  output logic [15:0]       fmap_wr_addr,
  output logic [DATA_W-1:0] fmap_wr_data,
  output logic              busy,
  output logic              pass_done,
  output logic              err
);

  localparam int COL_W = $clog2(ROW_LEN);
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(ROW_LEN - 1);
  localparam logic [COL_W-1:0]  COL_LIM  = COL_W'(COL_VALID);
  localparam logic [15:0]       PIX_LAST = 16'(PIX_TOTAL - 1);
  localparam logic [ACC_W-1:0]  ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0]  ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] PIX_MAX  = {1'b0, {(DATA_W-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // Two's-complement add that clamps to the signed ACC_W range instead of wrapping.
  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b);
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (s[ACC_W] != s[ACC_W-1]) return s[ACC_W] ? ACC_MIN : ACC_MAX;
    return s[ACC_W-1:0];
  endfunction

  state_t            state, state_nx;
  logic [COL_W-1:0]  col;
  logic [15:0]       pix;
  logic              first_q, last_q;
  logic [DATA_W-1:0] bias_q;
  logic              start_ok, accept;

  logic              s1_v, s2_v;
  logic [15:0]       s1_pix, s2_pix;
  logic [ACC_W-1:0]  s1_data, s2_data;

  logic [ACC_W-1:0]  addend, sum, biased;
  logic [DATA_W-1:0] relu;

  assign start_ok  = pass_start && (state == IDLE);
  assign accept    = (state == RUN) && in_valid && (col < COL_LIM);
  assign busy      = (state != IDLE);
  assign pass_done = (state == DONE);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (pass_start) state_nx = RUN;
      RUN:     if (accept && pix == PIX_LAST) state_nx = DRAIN;
      DRAIN:   if (!s1_v && !s2_v) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      col     <= '0;
      pix     <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      bias_q  <= '0;
      err     <= 1'b0;
    end else begin
      state <= state_nx;
      if (start_ok) begin
        col     <= '0;
        pix     <= '0;
        first_q <= first_pass;
        last_q  <= last_pass;
        bias_q  <= bias_in;
      end else if (state == RUN && in_valid) begin
        col <= (col == COL_LAST) ? '0 : col + 1'b1;
        if (accept) pix <= (pix == PIX_LAST) ? '0 : pix + 16'd1;
      end
      if ((in_valid && state != RUN) || (pass_start && state != IDLE)) err <= 1'b1;
    end
  end

  // Read issue and alignment: stage 2 lines up with the psum data returning from RAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_v         <= 1'b0;
      s1_pix       <= '0;
      s1_data      <= '0;
      s2_v         <= 1'b0;
      s2_pix       <= '0;
      s2_data      <= '0;
      psum_rd_en   <= 1'b0;
      psum_rd_addr <= '0;
    end else begin
      s1_v       <= accept;
      psum_rd_en <= accept && !first_q;
      if (accept) begin
        s1_pix  <= pix;
        s1_data <= in_data;
        if (!first_q) psum_rd_addr <= pix;
      end
      s2_v <= s1_v;
      if (s1_v) begin
        s2_pix  <= s1_pix;
        s2_data <= s1_data;
      end
    end
  end

  always_comb begin
    addend = first_q ? '0 : psum_rd_data;
    sum    = sat_add(addend, s2_data);
    biased = sat_add(sum, {{(ACC_W-DATA_W){bias_q[DATA_W-1]}}, bias_q});
    relu   = biased[DATA_W-1:0];
    if (biased[ACC_W-1]) relu = '0;
    else if (|biased[ACC_W-2:DATA_W-1]) relu = PIX_MAX;
  end

  // Retire stage: exactly one of the two write ports fires per retiring pixel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      psum_wr_en   <= 1'b0;
      psum_wr_addr <= '0;
      psum_wr_data <= '0;
      fmap_wr_en   <= 1'b0;
      fmap_wr_addr <= '0;
      fmap_wr_data <= '0;
    end else begin
      psum_wr_en <= s2_v && !last_q;
      fmap_wr_en <= s2_v && last_q;
      if (s2_v && !last_q) begin
        psum_wr_addr <= s2_pix;
        psum_wr_data <= sum;
      end
      if (s2_v && last_q) begin
        fmap_wr_addr <= s2_pix;
        fmap_wr_data <= relu;
      end
    end
  end

endmodule

// File: tb/tb_conv_writeback.sv
// Self-checking bench for conv_writeback: a table of single-pixel arithmetic corners,
// partial passes aborted by reset, and one full single-channel pass against a queue-based model.
module tb_conv_writeback;

  localparam int DATA_W    = 16;
  localparam int ACC_W     = 32;
  localparam int ROW_LEN   = 226;
  localparam int COL_VALID = 224;
  localparam int PIX_TOTAL = 50176;
  localparam longint AMAX  = 64'sd2147483647;
  localparam longint AMIN  = -AMAX - 1;

  logic              clk = 1'b0;
  logic              reset, pass_start, first_pass, last_pass;
  logic [DATA_W-1:0] bias_in;
  logic              in_valid;
  logic [ACC_W-1:0]  in_data;
  logic              psum_rd_en, psum_wr_en, fmap_wr_en, busy, pass_done, err;
  logic [15:0]       psum_rd_addr, psum_wr_addr, fmap_wr_addr;
  logic [ACC_W-1:0]  psum_rd_data, psum_wr_data;
  logic [DATA_W-1:0] fmap_wr_data;

  conv_writeback #(
    .DATA_W(DATA_W), .ACC_W(ACC_W), .ROW_LEN(ROW_LEN),
    .COL_VALID(COL_VALID), .PIX_TOTAL(PIX_TOTAL)
  ) dut (
    .clk(clk), .reset(reset), .pass_start(pass_start), .first_pass(first_pass),
    .last_pass(last_pass), .bias_in(bias_in), .in_valid(in_valid), .in_data(in_data),
    .psum_rd_en(psum_rd_en), .psum_rd_addr(psum_rd_addr), .psum_rd_data(psum_rd_data),
    .psum_wr_en(psum_wr_en), .psum_wr_addr(psum_wr_addr), .psum_wr_data(psum_wr_data),
    .fmap_wr_en(fmap_wr_en), .fmap_wr_addr(fmap_wr_addr), .fmap_wr_data(fmap_wr_data),
    .busy(busy), .pass_done(pass_done), .err(err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Environment memories: psum RAM with one-cycle read latency, captured feature map.
  int          ram      [PIX_TOTAL];
  int          fmap_mem [PIX_TOTAL];
  logic        pre_we;
  logic [15:0] pre_addr;
  logic [31:0] pre_data;

  always @(posedge clk) begin
    if (psum_rd_en) psum_rd_data <= ram[psum_rd_addr];
    if (psum_wr_en) ram[psum_wr_addr] <= int'(psum_wr_data);
    if (pre_we)     ram[pre_addr] <= int'(pre_data);
    if (fmap_wr_en) fmap_mem[fmap_wr_addr] <= int'(fmap_wr_data);
  end

  // Reference model: expected transactions keyed by the cycle they must appear in.
  typedef struct { int due; bit is_fmap; int addr; longint data; } wr_t;
  typedef struct { int due; int addr; } rd_t;
  wr_t wr_q[$];
  rd_t rd_q[$];
  int  mdl_psum [PIX_TOTAL];
  bit  m_first, m_last;
  int  m_bias, m_k, m_acc;
  int  fmap_count, rd_count, done_count, done_cyc;

  task automatic check(input string name, input longint got, input longint exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, got, exp);
    end
  endtask

  function automatic longint sat(input longint x);
    if (x > AMAX) return AMAX;
    if (x < AMIN) return AMIN;
    return x;
  endfunction

  // Advance one clock, then compare every strobe against what the model expects now.
  task automatic tick();
    wr_t e;
    rd_t r;
    @(posedge clk);
    #1;
    cyc++;
    if (wr_q.size() > 0 && wr_q[0].due == cyc) begin
      e = wr_q.pop_front();
      check("wr_kind", {fmap_wr_en, psum_wr_en}, e.is_fmap ? 2 : 1);
      if (e.is_fmap) begin
        check("fmap_addr", fmap_wr_addr, e.addr);
        check("fmap_data", fmap_wr_data, e.data);
      end else begin
        check("psum_wr_addr", psum_wr_addr, e.addr);
        check("psum_wr_data", longint'(signed'(psum_wr_data)), e.data);
      end
    end else begin
      check("wr_idle", {fmap_wr_en, psum_wr_en}, 0);
    end
    if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
      r = rd_q.pop_front();
      check("rd_en", psum_rd_en, 1);
      check("rd_addr", psum_rd_addr, r.addr);
    end else begin
      check("rd_idle", psum_rd_en, 0);
    end
    if (fmap_wr_en) fmap_count++;
    if (psum_rd_en) rd_count++;
    if (pass_done) begin
      done_count++;
      done_cyc = cyc;
    end
  endtask

  // One result entering the writeback in the current cycle: map it to a pixel from the
  // raw stream position, then predict the read and the final write.
  task automatic model_valid(input int d);
    int col, row, pix, px;
    longint s, v;
    col = m_k % ROW_LEN;
    row = m_k / ROW_LEN;
    m_k++;
    if (col >= COL_VALID) return;
    pix = row * COL_VALID + col;
    m_acc++;
    s = sat((m_first ? 64'sd0 : longint'(mdl_psum[pix])) + longint'(d));
    if (!m_first) rd_q.push_back('{cyc + 1, pix});
    if (m_last) begin
      v  = sat(s + longint'(m_bias));
      px = (v < 0) ? 0 : ((v > 32767) ? 32767 : int'(v));
      wr_q.push_back('{cyc + 3, 1'b1, pix, longint'(px)});
    end else begin
      wr_q.push_back('{cyc + 3, 1'b0, pix, s});
      mdl_psum[pix] = int'(s);
    end
  endtask

  task automatic preload(input int addr, input int val);
    pre_we = 1'b1;
    pre_addr = 16'(addr);
    pre_data = val;
    mdl_psum[addr] = val;
    tick();
    pre_we = 1'b0;
  endtask

  task automatic start_pass(input bit f, input bit l, input int b);
    pass_start = 1'b1;
    first_pass = f;
    last_pass  = l;
    bias_in    = 16'(b);
    m_first = f;
    m_last  = l;
    m_bias  = b;
    m_k     = 0;
    m_acc   = 0;
    tick();
    pass_start = 1'b0;
  endtask

  task automatic drive_valid(input int d);
    in_valid = 1'b1;
    in_data  = d;
    model_valid(d);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_strobes"}, {psum_rd_en, psum_wr_en, fmap_wr_en, busy, pass_done, err}, 0);
    check({tag, "_addrs"}, {psum_rd_addr, psum_wr_addr, fmap_wr_addr}, 0);
    check({tag, "_data"}, {psum_wr_data, fmap_wr_data}, 0);
  endtask

  // Asynchronous abort in the middle of a cycle; outputs must clear before the next edge.
  task automatic reset_mid(input string tag);
    #2 reset = 1'b1;
    #1;
    check_zero(tag);
    wr_q.delete();
    rd_q.delete();
    in_valid   = 1'b0;
    pass_start = 1'b0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  typedef struct {
    bit f; bit l; int bias; int psum; int din; bit exp_fmap; int exp_data;
  } vec_t;
  vec_t tbl[13];

  int last_valid_cyc;

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 5,      0,            0,         1'b1, 5};
    tbl[1]  = '{1'b0, 1'b1, 0,      40000,        0,         1'b1, 32767};
    tbl[2]  = '{1'b0, 1'b0, 0,      32'h7FFFFFF0, 32'h100,   1'b0, 32'h7FFFFFFF};
    tbl[3]  = '{1'b0, 1'b1, 2,      -10,          3,         1'b1, 0};
    tbl[4]  = '{1'b1, 1'b0, 0,      1234,         -10,       1'b0, -10};
    tbl[5]  = '{1'b0, 1'b0, 0,      32'h80000010, -256,      1'b0, 32'h80000000};
    tbl[6]  = '{1'b0, 1'b1, -1,     32'h80000000, 0,         1'b1, 0};
    tbl[7]  = '{1'b0, 1'b1, 32767,  32'h7FFFFFFF, 1,         1'b1, 32767};
    tbl[8]  = '{1'b1, 1'b1, -3,     0,            100,       1'b1, 97};
    tbl[9]  = '{1'b0, 1'b1, 0,      32767,        0,         1'b1, 32767};
    tbl[10] = '{1'b0, 1'b1, 1,      32766,        0,         1'b1, 32767};
    tbl[11] = '{1'b0, 1'b1, 0,      32768,        -2,        1'b1, 32766};
    tbl[12] = '{1'b0, 1'b1, -32768, 0,            32768,     1'b1, 0};

    reset = 1'b1; pass_start = 1'b0; first_pass = 1'b0; last_pass = 1'b0;
    bias_in = '0; in_valid = 1'b0; in_data = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    #3;
    check_zero("por");
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Arithmetic corners, one pixel at address 0 per vector.
    for (int i = 0; i < 13; i++) begin
      preload(0, tbl[i].psum);
      start_pass(tbl[i].f, tbl[i].l, tbl[i].bias);
      drive_valid(tbl[i].din);
      tick();
      tick();
      check($sformatf("vec%0d_kind", i), {fmap_wr_en, psum_wr_en}, tbl[i].exp_fmap ? 2 : 1);
      if (tbl[i].exp_fmap) check($sformatf("vec%0d_fmap", i), fmap_wr_data, tbl[i].exp_data);
      else check($sformatf("vec%0d_psum", i), longint'(signed'(psum_wr_data)), tbl[i].exp_data);
      reset_mid($sformatf("vec%0d_rst", i));
    end

    // Two partial passes: write -10, then read back, add 3 and bias 2 -> ReLU gives 0.
    start_pass(1'b1, 1'b0, 0);
    for (int k = 0; k < 300; k++) drive_valid(-10);
    for (int k = 0; k < 4; k++) tick();
    check("passA_ram5", ram[5], -10);
    reset_mid("passA_rst");
    start_pass(1'b0, 1'b1, 2);
    for (int k = 0; k < 300; k++) drive_valid(3);
    for (int k = 0; k < 4; k++) tick();
    reset_mid("passB_rst");

    // Random gaps and data, aborted by reset once 1000 pixels are in.
    start_pass(1'b0, 1'b0, 0);
    for (int it = 0; it < 6000 && m_acc < 1000; it++) begin
      if ($urandom_range(1) == 1) drive_valid(int'($urandom));
      else tick();
    end
    check("gap_reached_1000", m_acc, 1000);
    reset_mid("gap_rst");
    for (int k = 0; k < 3; k++) tick();
    start_pass(1'b1, 1'b0, 0);
    for (int k = 0; k < 10; k++) drive_valid(k + 1);
    for (int k = 0; k < 4; k++) tick();
    reset_mid("restart_rst");

    // Full single-channel pass with protocol errors injected around it.
    fmap_count = 0; rd_count = 0; done_count = 0; done_cyc = 0;
    check("err_clear", err, 0);
    in_valid = 1'b1;
    in_data  = 55;
    tick();
    in_valid = 1'b0;
    check("err_idle_valid", err, 1);
    in_valid = 1'b1;
    in_data  = 77;
    start_pass(1'b1, 1'b1, 5);
    in_valid = 1'b0;
    for (int k = 0; k < ROW_LEN * COL_VALID - 2; k++) begin
      if (k == 20000) begin
        pass_start = 1'b1;
        first_pass = 1'b0;
        last_pass  = 1'b0;
        bias_in    = 16'd99;
      end
      last_valid_cyc = cyc;
      drive_valid(k % ROW_LEN);
      pass_start = 1'b0;
      if (k == 100) check("busy_run", busy, 1);
    end
    for (int n = 0; n < 20 && done_count == 0; n++) tick();
    check("pass_done_seen", done_count, 1);
    tick();
    tick();
    check("pass_done_pulses", done_count, 1);
    check("pass_done_latency", done_cyc - last_valid_cyc, 4);
    check("fmap_count", fmap_count, PIX_TOTAL);
    check("psum_rd_count", rd_count, 0);
    check("fmap_px0", fmap_mem[0], 5);
    check("fmap_px223", fmap_mem[223], 228);
    check("fmap_px224", fmap_mem[224], 5);
    check("fmap_px_last", fmap_mem[PIX_TOTAL-1], 228);
    check("err_sticky", err, 1);
    check("busy_idle", busy, 0);
    check("queue_empty", wr_q.size() + rd_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
